// File: rtl/fu_cdb_arbiter.sv
// Functional-unit result buffers feeding a single common data bus.
// One buffer entry per FU, round-robin grant, valid/ready handshake on both sides.
module fu_cdb_arbiter #(
    parameter int NUM_FU = 6,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_value,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic                           cdb_ready,
    output logic                           cdb_valid,
    output logic [TAG_W-1:0]               cdb_tag,
    output logic [DATA_W-1:0]              cdb_value,
    output logic [2:0]                     cdb_fu_idx,
    output logic [NUM_FU-1:0]              rs_free,
    output logic [2:0]                     occupancy
);

    logic [NUM_FU-1:0]             buf_valid_q, buf_valid_d;
    logic [NUM_FU-1:0][TAG_W-1:0]  buf_tag_q,   buf_tag_d;
    logic [NUM_FU-1:0][DATA_W-1:0] buf_value_q, buf_value_d;
    logic [2:0]                    rr_ptr_q,    rr_ptr_d;

    logic [NUM_FU-1:0] grant_oh;
    logic [2:0]        grant_idx;
    logic              grant_found;
    logic              handshake;

    // Two passes: entries at or above rr_ptr first, then wrap to the low entries.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (!grant_found && buf_valid_q[i] && (i >= 32'(rr_ptr_q))) begin
                grant_found = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = 3'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (!grant_found && buf_valid_q[i]) begin
                grant_found = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = 3'(i);
            end
        end
    end

    assign cdb_valid = (|buf_valid_q) && !flush;
    // Reset suppresses the handshake so a squashed broadcast never frees a station.
    assign handshake = cdb_valid && cdb_ready && !reset;
    assign fu_ready  = ~buf_valid_q;
    assign rs_free   = handshake ? grant_oh : '0;

    always_comb begin
        cdb_tag    = '0;
        cdb_value  = '0;
        cdb_fu_idx = '0;
        if (cdb_valid) begin
            cdb_fu_idx = grant_idx;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (grant_oh[i]) begin
                    cdb_tag   = buf_tag_q[i];
                    cdb_value = buf_value_q[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            occupancy = occupancy + 3'(buf_valid_q[i]);
        end
    end

    // Loads only target empty entries and the handshake only clears a full one,
    // so the two updates never touch the same entry in one cycle.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_value_d = buf_value_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            buf_valid_d = '0;
            rr_ptr_d    = '0;
        end else begin
            if (handshake) begin
                buf_valid_d = buf_valid_d & ~grant_oh;
                rr_ptr_d    = (grant_idx == 3'(NUM_FU - 1)) ? 3'd0 : grant_idx + 3'd1;
            end
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && !buf_valid_q[i]) begin
                    buf_valid_d[i] = 1'b1;
                    buf_tag_d[i]   = fu_tag[i];
                    buf_value_d[i] = fu_value[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid_q <= '0;
            buf_tag_q   <= '0;
            buf_value_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_value_q <= buf_value_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Bench for fu_cdb_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a queue-free array model of the buffers.
module tb_fu_cdb_arbiter;

    localparam int NUM = 6;
    localparam int DW  = 32;
    localparam int TW  = 6;

    logic                     clk = 1'b0;
    logic                     reset, flush, cdb_ready;
    logic [NUM-1:0]           fu_valid;
    logic [NUM-1:0][TW-1:0]   fu_tag;
    logic [NUM-1:0][DW-1:0]   fu_value;
    logic [NUM-1:0]           fu_ready, rs_free;
    logic                     cdb_valid;
    logic [TW-1:0]            cdb_tag;
    logic [DW-1:0]            cdb_value;
    logic [2:0]               cdb_fu_idx, occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    fu_cdb_arbiter #(.NUM_FU(NUM), .DATA_W(DW), .TAG_W(TW)) dut (
        .clock(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
        .fu_ready(fu_ready), .cdb_ready(cdb_ready), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_fu_idx(cdb_fu_idx),
        .rs_free(rs_free), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: one slot per FU, pointer to the first slot to consider.
    bit          mv[NUM];
    logic [TW-1:0] mtag[NUM];
    logic [DW-1:0] mval[NUM];
    int          mptr    = 0;
    bit          started = 1'b0;

    function automatic int model_grant();
        for (int k = 0; k < NUM; k++) begin
            int j;
            j = (mptr + k) % NUM;
            if (mv[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit was_full[NUM];
        int g;
        if (reset) begin
            started = 1'b1;
            for (int i = 0; i < NUM; i++) begin
                mv[i] = 0; mtag[i] = '0; mval[i] = '0;
            end
            mptr = 0;
        end else if (flush) begin
            for (int i = 0; i < NUM; i++) mv[i] = 0;
            mptr = 0;
        end else begin
            for (int i = 0; i < NUM; i++) was_full[i] = mv[i];
            g = model_grant();
            if (g >= 0 && cdb_ready) begin
                mv[g] = 0;
                mptr  = (g + 1) % NUM;
            end
            for (int i = 0; i < NUM; i++) begin
                if (fu_valid[i] && !was_full[i]) begin
                    mv[i] = 1; mtag[i] = fu_tag[i]; mval[i] = fu_value[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        int g, cnt;
        logic [NUM-1:0] exp_ready, exp_free;
        bit exp_valid;
        if (started) begin
            g   = model_grant();
            cnt = 0;
            for (int i = 0; i < NUM; i++) begin
                exp_ready[i] = !mv[i];
                cnt += int'(mv[i]);
            end
            exp_valid = (g >= 0) && !flush;
            exp_free  = '0;
            if (exp_valid && cdb_ready && !reset) exp_free[g] = 1'b1;
            chk("m_fu_ready", 64'(fu_ready), 64'(exp_ready));
            chk("m_cdb_valid", 64'(cdb_valid), 64'(exp_valid));
            chk("m_occupancy", 64'(occupancy), 64'(cnt));
            chk("m_rs_free", 64'(rs_free), 64'(exp_free));
            chk("m_cdb_idx", 64'(cdb_fu_idx), exp_valid ? 64'(g) : 64'd0);
            chk("m_cdb_tag", 64'(cdb_tag), exp_valid ? 64'(mtag[g]) : 64'd0);
            chk("m_cdb_value", 64'(cdb_value), exp_valid ? 64'(mval[g]) : 64'd0);
        end
    end

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tagn);
        chk({tagn, "_fu_ready"}, 64'(fu_ready), 64'h3F);
        chk({tagn, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
        chk({tagn, "_cdb_tag"}, 64'(cdb_tag), 64'd0);
        chk({tagn, "_cdb_value"}, 64'(cdb_value), 64'd0);
        chk({tagn, "_cdb_idx"}, 64'(cdb_fu_idx), 64'd0);
        chk({tagn, "_rs_free"}, 64'(rs_free), 64'd0);
        chk({tagn, "_occupancy"}, 64'(occupancy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_ready = 1'b0;
        fu_valid = '0; fu_tag = '0; fu_value = '0;
        advance(); advance();
        reset = 1'b0;
        sample(); chk_idle("reset");
        advance();

        // Single accept on FU 2
        fu_valid = 6'b000100; fu_tag[2] = 6'h11; fu_value[2] = 32'hDEAD; cdb_ready = 1'b1;
        advance();
        fu_valid = '0;
        sample();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_idx", 64'(cdb_fu_idx), 64'd2);
        chk("single_tag", 64'(cdb_tag), 64'h11);
        chk("single_value", 64'(cdb_value), 64'hDEAD);
        chk("single_rs_free", 64'(rs_free), 64'b000100);
        chk("single_fu_ready", 64'(fu_ready), 64'b111011);
        advance();
        sample();
        chk("single_refill_ready", 64'(fu_ready), 64'h3F);
        chk("single_drained", 64'(cdb_valid), 64'd0);
        advance();

        // Flush an empty arbiter to bring the pointer back to 0, then load all six
        flush = 1'b1;
        advance();
        flush = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            fu_tag[i]   = 6'(32 + i);
            fu_value[i] = 32'h1000 + 32'(i);
        end
        fu_valid = 6'h3F;
        advance();
        fu_valid = '0;
        for (int k = 0; k < NUM; k++) begin
            sample();
            chk("all6_idx", 64'(cdb_fu_idx), 64'(k));
            chk("all6_occ", 64'(occupancy), 64'(NUM - k));
            chk("all6_rs_free", 64'(rs_free), 64'(1) << k);
            chk("all6_tag", 64'(cdb_tag), 64'(32 + k));
            advance();
        end
        sample();
        chk("all6_empty_occ", 64'(occupancy), 64'd0);
        chk("all6_empty_valid", 64'(cdb_valid), 64'd0);

        // Backpressure with buffers 1 and 4 full
        cdb_ready = 1'b0;
        fu_tag[1] = 6'h0A; fu_value[1] = 32'hAAAA_0001;
        fu_tag[4] = 6'h0B; fu_value[4] = 32'hBBBB_0004;
        fu_valid  = 6'b010010;
        advance();
        fu_valid = 6'b000010; fu_tag[1] = 6'h3F; fu_value[1] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("bp_valid", 64'(cdb_valid), 64'd1);
            chk("bp_idx", 64'(cdb_fu_idx), 64'd1);
            chk("bp_tag", 64'(cdb_tag), 64'h0A);
            chk("bp_value", 64'(cdb_value), 64'hAAAA_0001);
            chk("bp_fu_ready", 64'(fu_ready), 64'b101101);
            chk("bp_rs_free", 64'(rs_free), 64'd0);
            advance();
        end
        fu_valid = '0; cdb_ready = 1'b1;
        sample();
        chk("bp_grant1", 64'(rs_free), 64'b000010);
        advance();
        sample();
        chk("bp_grant4", 64'(rs_free), 64'b010000);
        chk("bp_tag4", 64'(cdb_tag), 64'h0B);
        advance();

        // Pointer now at 5: buffers 0 and 5 -> 5 first, then 0
        cdb_ready = 1'b0;
        fu_tag[0] = 6'h01; fu_value[0] = 32'h100;
        fu_tag[5] = 6'h05; fu_value[5] = 32'h500;
        fu_valid  = 6'b100001;
        advance();
        fu_valid = '0; cdb_ready = 1'b1;
        sample();
        chk("wrap_first_idx", 64'(cdb_fu_idx), 64'd5);
        chk("wrap_first_free", 64'(rs_free), 64'b100000);
        advance();
        sample();
        chk("wrap_second_idx", 64'(cdb_fu_idx), 64'd0);
        chk("wrap_second_tag", 64'(cdb_tag), 64'h01);
        advance();

        // Flush with three full buffers and a same-cycle load on FU 0
        cdb_ready = 1'b0;
        fu_valid  = 6'b001110;
        advance();
        fu_valid = 6'b000001; fu_tag[0] = 6'h2A; flush = 1'b1; cdb_ready = 1'b1;
        sample();
        chk("flush_occ_before", 64'(occupancy), 64'd3);
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_rs_free", 64'(rs_free), 64'd0);
        chk("flush_tag", 64'(cdb_tag), 64'd0);
        advance();
        flush = 1'b0; fu_valid = '0; cdb_ready = 1'b0;
        sample();
        chk_idle("flush_after");
        advance();

        // Pointer reset by flush: buffers 0 and 3 -> 0 wins
        fu_valid = 6'b001001;
        advance();
        fu_valid = '0;
        sample();
        chk("flush_ptr_idx", 64'(cdb_fu_idx), 64'd0);
        cdb_ready = 1'b1;
        advance(); advance();

        // Reset while a broadcast is stalled
        cdb_ready = 1'b0; fu_valid = 6'b000100;
        advance();
        fu_valid = 6'b000001; reset = 1'b1;
        sample();
        chk("rst_stall_rs_free", 64'(rs_free), 64'd0);
        advance();
        reset = 1'b0; fu_valid = '0;
        sample(); chk_idle("rst_stall");
        advance();

        // Reset while the consumer is ready: no rs_free pulse
        fu_valid = 6'b010000;
        advance();
        fu_valid = '0; reset = 1'b1; cdb_ready = 1'b1;
        sample();
        chk("rst_ready_rs_free", 64'(rs_free), 64'd0);
        advance();
        reset = 1'b0;
        sample(); chk_idle("rst_ready");
        advance();

        // Reset and flush together with loads pending
        cdb_ready = 1'b0; fu_valid = 6'b110000;
        advance();
        reset = 1'b1; flush = 1'b1; fu_valid = 6'h3F;
        advance();
        reset = 1'b0; flush = 1'b0; fu_valid = '0;
        sample(); chk_idle("rst_flush");
        fu_valid = 6'b000110;
        advance();
        fu_valid = '0;
        sample();
        chk("rst_flush_ptr_idx", 64'(cdb_fu_idx), 64'd1);
        advance();

        // Mixed traffic checked by the model every cycle
        for (int c = 0; c < 60; c++) begin
            fu_valid  = 6'((c * 13) ^ (c >> 1));
            cdb_ready = (c % 3) != 0;
            flush     = (c == 37);
            for (int i = 0; i < NUM; i++) begin
                fu_tag[i]   = 6'(c + i);
                fu_value[i] = 32'(c * 256 + i);
            end
            advance();
        end
        fu_valid = '0; flush = 1'b0; cdb_ready = 1'b1;
        for (int c = 0; c < 8; c++) advance();
        sample();
        chk("final_occ", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_cdb_arbiter.md
FU_CDB_ARBITER -- requirements
Module: fu_cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 6, number of functional-unit requesters (index 0..5: ALU_1, ALU_2, ALU_3, MULT_1, MULT_2, BRANCH).
REQ-002 SHALL have parameter DATA_W, default 32 (`XLEN), result value width.
REQ-003 SHALL have parameter TAG_W, default 6, physical-register tag width.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-006 SHALL have port flush  in  1  squash request; discards all buffered results.
REQ-007 SHALL have port fu_valid  in  NUM_FU  per-FU result-valid.
REQ-008 SHALL have port fu_tag  in  NUM_FU x TAG_W  per-FU destination tag.
REQ-009 SHALL have port fu_value  in  NUM_FU x DATA_W  per-FU result value.
REQ-010 SHALL have port fu_ready  out  NUM_FU  per-FU buffer-free; FU holds its result while low.
REQ-011 SHALL have port cdb_ready  in  1  consumer accepts broadcast this cycle.
REQ-012 SHALL have port cdb_valid  out  1  broadcast valid.
REQ-013 SHALL have port cdb_tag  out  TAG_W  broadcast tag.
REQ-014 SHALL have port cdb_value  out  DATA_W  broadcast value.
REQ-015 SHALL have port cdb_fu_idx  out  3  index of granted FU.
REQ-016 SHALL have port rs_free  out  NUM_FU  one-hot pulse; granted FU may be reissued.
REQ-017 SHALL have port occupancy  out  3  count of full buffers, 0..6.

Function
REQ-018 SHALL hold one result-buffer entry per FU (valid, tag, value).
REQ-019 SHALL drive fu_ready[i] = !buf_valid[i], registered state only, no combinational path from any input.
REQ-020 SHALL load buffer i on rising edge when fu_valid[i] && fu_ready[i] && !flush; fu_valid with fu_ready low is ignored (FU must hold).
REQ-021 SHALL be round-robin: search from rr_ptr upward with wrap 5->0; first buf_valid wins; grant is combinational from registered state.
REQ-022 SHALL drive cdb_valid = |buf_valid && !flush; cdb_tag, cdb_value, cdb_fu_idx from the granted entry, all forced to 0 when cdb_valid is low.
REQ-023 SHALL complete a handshake when cdb_valid && cdb_ready: granted buffer cleared next edge; rs_free[grant]=1 that same cycle (combinational); rr_ptr <= (grant==5) ? 0 : grant+1.
REQ-024 SHALL hold without handshake: buffers, grant, outputs and rr_ptr stable; broadcast data must not change while cdb_valid && !cdb_ready.
REQ-025 SHALL not bypass: minimum latency is fu_valid accepted at edge N -> cdb_valid in cycle N+1; a buffer cleared at edge N reads fu_ready=1 in cycle N+1 (one-cycle refill bubble).
REQ-026 SHALL bound starvation: a full buffer is granted within NUM_FU handshakes.
REQ-027 SHALL on flush: clear all buffer valids and reset rr_ptr to 0 at the next edge; same-cycle loads are dropped; rs_free = 0 that cycle.
REQ-028 SHALL drive occupancy = popcount(buf_valid), registered-state based.
REQ-029 SHALL, when reset and flush are both high, treat reset as dominant (identical end state).

Reset
REQ-030 SHALL, when reset is high at a rising edge, clear buf_valid to 0, tags/values to 0, and rr_ptr to 0, regardless of flush, fu_valid or cdb_ready.
REQ-031 SHALL present, in the cycle after reset: fu_ready = 6'b111111, cdb_valid = 0, cdb_tag/cdb_value/cdb_fu_idx = 0, rs_free = 0, occupancy = 0.
REQ-032 SHALL discard, on reset asserted mid-operation, any pending broadcast, with no rs_free pulse emitted.

Verification
REQ-033 SHALL cover: single accept: fu_valid[2]=1, tag=0x11, value=0xDEAD, cdb_ready=1 -> next cycle cdb_valid=1, cdb_fu_idx=2, tag 0x11, rs_free=6'b000100; fu_ready[2]=1 the cycle after.
REQ-034 SHALL cover: all six FUs valid in one cycle, cdb_ready=1 -> grants 0,1,2,3,4,5 on consecutive cycles, occupancy 6,5,4,3,2,1 then 0.
REQ-035 SHALL cover: backpressure: buffers 1 and 4 full, cdb_ready=0 for 3 cycles -> cdb_fu_idx=1 with tag/value stable, fu_ready[1]=0; then cdb_ready=1 -> grant 1, then 4.
REQ-036 SHALL cover: wrap fairness: rr_ptr=5 after granting 4, buffers 0 and 5 full -> grant 5 first, then 0.
REQ-037 SHALL cover: flush with occupancy 3 and fu_valid[0]=1 -> next cycle occupancy=0, cdb_valid=0, buffer 0 not loaded, rs_free=0.
REQ-038 SHALL cover: reset asserted while cdb_valid=1, cdb_ready=0 -> next cycle all outputs at REQ-031 values.
